// File: rtl/crypt_job_engine.sv
// Keyed round engine for encrypt/decrypt/replay jobs, fed by a small command FIFO.
// Optional error counter output Err_count is enabled by defining CRYPT_ERR_CNT_EN.
module crypt_job_engine #(
    parameter int RAW_W      = 60,
    parameter int TAG_W      = 18,
    parameter int ROUNDS     = 4,
    parameter int ROT        = 7,
    parameter int FIFO_DEPTH = 4,
    localparam int ENC_W     = RAW_W + TAG_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [1:0]       In_mode,
    input  logic [ENC_W-1:0] In_data,
    input  logic [RAW_W-1:0] Key,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [1:0]       Out_mode,
    output logic [ENC_W-1:0] Out_data,
    output logic             Out_tag_err,
    output logic             Busy,
    output logic [15:0]      Job_count
`ifdef CRYPT_ERR_CNT_EN
    ,
    output logic [7:0]       Err_count
`endif
);

    // state | meaning
    // IDLE  | waiting for a command; pops the FIFO head when one is present
    // RUN   | one cipher round per edge; last round registers the result
    // OUT   | result presented on Out_*, held until Out_ready
    typedef enum logic [1:0] {IDLE, RUN, OUT} stateT;

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int RCW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int ROT_M = ROT % RAW_W;
    localparam int NCH   = (RAW_W + TAG_W - 1) / TAG_W;
    localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [RCW-1:0] RC_ONE  = {{(RCW-1){1'b0}}, 1'b1};
    localparam logic [RCW-1:0] RC_LAST = RCW'(ROUNDS - 1);

    function automatic logic [RAW_W-1:0] rotl(input logic [RAW_W-1:0] v, input logic [31:0] amt);
        logic [2*RAW_W-1:0] d;
        d = {v, v} << amt;
        return d[2*RAW_W-1 -: RAW_W];
    endfunction

    function automatic logic [RAW_W-1:0] rotr(input logic [RAW_W-1:0] v, input logic [31:0] amt);
        logic [2*RAW_W-1:0] d;
        d = {v, v} >> amt;
        return d[RAW_W-1:0];
    endfunction

    // XOR-fold of the plaintext in TAG_W-bit chunks, top chunk zero-padded
    function automatic logic [TAG_W-1:0] tagFold(input logic [RAW_W-1:0] p);
        logic [NCH*TAG_W-1:0] padded;
        logic [TAG_W-1:0]     t;
        padded            = '0;
        padded[RAW_W-1:0] = p;
        t                 = '0;
        for (int i = 0; i < NCH; i++) t ^= padded[i*TAG_W +: TAG_W];
        return t;
    endfunction

    stateT state;

    logic [ENC_W+1:0] fifoMem [FIFO_DEPTH];
    logic [AW:0]      wrPtr, rdPtr;
    logic             fifoFull, fifoEmpty, doPush, doPop;
    logic [ENC_W+1:0] fifoHead;

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign In_ready  = !fifoFull;
    assign doPush    = In_valid && !fifoFull;
    assign doPop     = (state == IDLE) && !fifoEmpty;
    assign fifoHead  = fifoMem[rdPtr[AW-1:0]];
    assign Busy      = (state != IDLE) || !fifoEmpty;

    always_ff @(posedge Clk) begin
        if (doPush) fifoMem[wrPtr[AW-1:0]] <= {In_mode, In_data};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    logic [RAW_W-1:0] xReg, keyReg, plainReg, lastPlain;
    logic [TAG_W-1:0] rxTag;
    logic [RCW-1:0]   roundsLeft;
    logic             isDec;
    logic [31:0]      rIdx, keyRot;
    logic [RAW_W-1:0] roundKey, xNext;

    // roundsLeft counts down for both directions; encrypt maps it to an ascending round index
    always_comb begin
        rIdx     = isDec ? 32'(roundsLeft) : (32'(ROUNDS - 1) - 32'(roundsLeft));
        keyRot   = (rIdx * 32'd5) % 32'(RAW_W);
        roundKey = rotl(keyReg, keyRot);
        xNext    = isDec ? (rotr(xReg, 32'(ROT_M)) ^ roundKey)
                         : rotl(xReg ^ roundKey, 32'(ROT_M));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            xReg        <= '0;
            keyReg      <= '0;
            plainReg    <= '0;
            lastPlain   <= '0;
            rxTag       <= '0;
            roundsLeft  <= '0;
            isDec       <= 1'b0;
            Out_valid   <= 1'b0;
            Out_mode    <= 2'd0;
            Out_data    <= '0;
            Out_tag_err <= 1'b0;
            Job_count   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifoEmpty) begin
                        keyReg   <= Key;
                        Out_mode <= fifoHead[ENC_W+1:ENC_W];
                        case (fifoHead[ENC_W+1:ENC_W])
                            2'd0: begin
                                xReg       <= fifoHead[RAW_W-1:0];
                                plainReg   <= fifoHead[RAW_W-1:0];
                                isDec      <= 1'b0;
                                roundsLeft <= RC_LAST;
                                state      <= RUN;
                            end
                            2'd1: begin
                                xReg       <= fifoHead[RAW_W-1:0];
                                rxTag      <= fifoHead[ENC_W-1:RAW_W];
                                isDec      <= 1'b1;
                                roundsLeft <= RC_LAST;
                                state      <= RUN;
                            end
                            2'd2: begin
                                Out_data    <= {{TAG_W{1'b0}}, lastPlain};
                                Out_tag_err <= 1'b0;
                                Out_valid   <= 1'b1;
                                state       <= OUT;
                            end
                            default: begin
                                Out_data    <= '0;
                                Out_tag_err <= 1'b1;
                                Out_valid   <= 1'b1;
                                state       <= OUT;
                            end
                        endcase
                    end
                end
                RUN: begin
                    xReg <= xNext;
                    if (roundsLeft == '0) begin
                        if (isDec) begin
                            Out_data    <= {{TAG_W{1'b0}}, xNext};
                            Out_tag_err <= (tagFold(xNext) != rxTag);
                            lastPlain   <= xNext;
                        end else begin
                            Out_data    <= {tagFold(plainReg), xNext};
                            Out_tag_err <= 1'b0;
                        end
                        Out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        roundsLeft <= roundsLeft - RC_ONE;
                    end
                end
                OUT: begin
                    if (Out_ready) begin
                        Out_valid <= 1'b0;
                        Job_count <= Job_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRYPT_ERR_CNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Err_count <= 8'd0;
        end else if (Out_valid && Out_ready && Out_tag_err && (Err_count != 8'hFF)) begin
            Err_count <= Err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crypt_job_engine.sv
// Directed bench for crypt_job_engine at default parameters (Err_count checked when CRYPT_ERR_CNT_EN is defined).
module tb_crypt_job_engine;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [1:0]  In_mode = 2'd0;
    logic [77:0] In_data = '0;
    logic [59:0] Key = '0;
    logic        Out_valid;
    logic        Out_ready = 1'b1;
    logic [1:0]  Out_mode;
    logic [77:0] Out_data;
    logic        Out_tag_err;
    logic        Busy;
    logic [15:0] Job_count;
`ifdef CRYPT_ERR_CNT_EN
    logic [7:0]  Err_count;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [77:0] EXP1 = {18'h00001, 60'h000000010000000};

    crypt_job_engine dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_valid(In_valid), .In_ready(In_ready), .In_mode(In_mode), .In_data(In_data),
        .Key(Key),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_mode(Out_mode),
        .Out_data(Out_data), .Out_tag_err(Out_tag_err),
        .Busy(Busy), .Job_count(Job_count)
`ifdef CRYPT_ERR_CNT_EN
        , .Err_count(Err_count)
`endif
    );

    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic resetDut();
        In_valid = 1'b0;
        Rst_n = 1'b0;
        repeat (2) tick();
        Rst_n = 1'b1;
    endtask

    task automatic push(input logic [1:0] m, input logic [77:0] d);
        In_valid = 1'b1;
        In_mode  = m;
        In_data  = d;
        tick();
        In_valid = 1'b0;
    endtask

    task automatic waitOut(input string name);
        int n = 0;
        while (!Out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!Out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s timeout got Out_valid=%0b exp=1", name, Out_valid);
        end
    endtask

    // Bit-serial fold: plaintext bit i lands on tag bit i mod 18
    function automatic logic [17:0] refTag(input logic [59:0] p);
        logic [17:0] t = '0;
        for (int i = 0; i < 60; i++) t[i % 18] ^= p[i];
        return t;
    endfunction

    task automatic test_reset();
        resetDut();
        checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", Out_valid); end
        checks++; if (Out_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", Out_data); end
        checks++; if (Out_mode !== 2'd0 || Out_tag_err !== 1'b0) begin failures++; $display("FAIL rst_mode_err got=%0d/%0b exp=0/0", Out_mode, Out_tag_err); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", Busy); end
        checks++; if (Job_count !== 16'd0) begin failures++; $display("FAIL rst_jobcnt got=%0d exp=0", Job_count); end
        checks++; if (In_ready !== 1'b1) begin failures++; $display("FAIL rst_inready got=%0b exp=1", In_ready); end
    endtask

    task automatic test_encrypt_latency();
        Key = '0;
        Out_ready = 1'b1;
        push(2'd0, 78'd1);
        repeat (4) tick();
        checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL t1_early_valid got=%0b exp=0", Out_valid); end
        tick();
        checks++; if (Out_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%0b exp=1", Out_valid); end
        checks++; if (Out_data !== EXP1) begin failures++; $display("FAIL t1_data got=%h exp=%h", Out_data, EXP1); end
        checks++; if (Out_tag_err !== 1'b0 || Out_mode !== 2'd0) begin failures++; $display("FAIL t1_err_mode got=%0b/%0d exp=0/0", Out_tag_err, Out_mode); end
        tick();
        checks++; if (Job_count !== 16'd1) begin failures++; $display("FAIL t1_jobcnt got=%0d exp=1", Job_count); end
        checks++; if (Out_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_drop got=%0b exp=0", Out_valid); end
    endtask

    task automatic test_decrypt_replay();
        push(2'd1, EXP1);
        waitOut("t2_dec");
        checks++; if (Out_data !== 78'd1) begin failures++; $display("FAIL t2_dec_data got=%h exp=1", Out_data); end
        checks++; if (Out_tag_err !== 1'b0 || Out_mode !== 2'd1) begin failures++; $display("FAIL t2_dec_err_mode got=%0b/%0d exp=0/1", Out_tag_err, Out_mode); end
        tick();
        push(2'd2, 78'h3FF);
        tick();
        checks++; if (Out_valid !== 1'b1) begin failures++; $display("FAIL t2_replay_latency got=%0b exp=1", Out_valid); end
        checks++; if (Out_data !== 78'd1 || Out_mode !== 2'd2 || Out_tag_err !== 1'b0) begin
            failures++; $display("FAIL t2_replay got=%h/%0d/%0b exp=1/2/0", Out_data, Out_mode, Out_tag_err); end
        tick();
    endtask

    task automatic test_tag_error();
        logic [77:0] bad;
        bad = EXP1 ^ (78'd1 << 60);
        push(2'd1, bad);
        waitOut("t3_dec");
        checks++; if (Out_data !== 78'd1) begin failures++; $display("FAIL t3_bad_plain got=%h exp=1", Out_data); end
        checks++; if (Out_tag_err !== 1'b1) begin failures++; $display("FAIL t3_bad_err got=%0b exp=1", Out_tag_err); end
        tick();
        push(2'd3, 78'h123);
        waitOut("t3_illegal");
        checks++; if (Out_data !== '0 || Out_tag_err !== 1'b1 || Out_mode !== 2'd3) begin
            failures++; $display("FAIL t3_illegal got=%h/%0b/%0d exp=0/1/3", Out_data, Out_tag_err, Out_mode); end
        tick();
`ifdef CRYPT_ERR_CNT_EN
        checks++; if (Err_count !== 8'd2) begin failures++; $display("FAIL t3_errcnt got=%0d exp=2", Err_count); end
`endif
        checks++; if (Job_count !== 16'd5) begin failures++; $display("FAIL t3_jobcnt got=%0d exp=5", Job_count); end
    endtask

    task automatic test_back_to_back();
        logic [77:0] held;
        logic [77:0] expv;
        logic [59:0] dd;
        resetDut();
        Key = '0;
        Out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            In_valid = 1'b1;
            In_mode  = 2'd0;
            In_data  = 78'(i + 10);
            checks++; if (In_ready !== (i < 5)) begin failures++; $display("FAIL t4_inready_%0d got=%0b exp=%0b", i, In_ready, (i < 5)); end
            tick();
        end
        In_valid = 1'b0;
        waitOut("t4_first");
        held = Out_data;
        repeat (3) tick();
        dd = 60'd10;
        expv = {dd[17:0], dd << 28};
        checks++; if (Out_valid !== 1'b1 || Out_data !== held || Out_data !== expv) begin
            failures++; $display("FAIL t4_stall_hold got=%h exp=%h", Out_data, expv); end
        Out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            waitOut("t4_drain");
            dd = 60'(j + 10);
            expv = {dd[17:0], dd << 28};
            checks++; if (Out_data !== expv) begin failures++; $display("FAIL t4_order_%0d got=%h exp=%h", j, Out_data, expv); end
            tick();
        end
        tick();
        checks++; if (Busy !== 1'b0 || Job_count !== 16'd5) begin
            failures++; $display("FAIL t4_done got busy=%0b cnt=%0d exp=0/5", Busy, Job_count); end
    endtask

    task automatic test_round_trip();
        logic [59:0] plain;
        logic [77:0] enc;
        resetDut();
        Out_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            Key   = 60'({$urandom(), $urandom()});
            plain = 60'({$urandom(), $urandom()});
            push(2'd0, {18'd0, plain});
            waitOut("t5_enc");
            enc = Out_data;
            checks++; if (enc[77:60] !== refTag(plain) || Out_tag_err !== 1'b0) begin
                failures++; $display("FAIL t5_enc_tag_%0d got=%h/%0b exp=%h/0", n, enc[77:60], Out_tag_err, refTag(plain)); end
            tick();
            push(2'd1, enc);
            waitOut("t5_dec");
            checks++; if (Out_data !== {18'd0, plain} || Out_tag_err !== 1'b0) begin
                failures++; $display("FAIL t5_roundtrip_%0d got=%h/%0b exp=%h/0", n, Out_data, Out_tag_err, plain); end
            tick();
        end
        checks++; if (Job_count !== 16'd400) begin failures++; $display("FAIL t5_jobcnt got=%0d exp=400", Job_count); end
    endtask

    task automatic test_reset_midflight();
        resetDut();
        Key = '0;
        Out_ready = 1'b1;
        push(2'd1, EXP1);
        waitOut("t6_dec_a");
        tick();
        push(2'd0, 78'd1);
        repeat (2) tick();
        Rst_n = 1'b0;
        #1;
        checks++; if (Out_valid !== 1'b0 || Busy !== 1'b0 || In_ready !== 1'b1 || Job_count !== 16'd0 || Out_data !== '0) begin
            failures++; $display("FAIL t6_run_rst got v=%0b b=%0b r=%0b c=%0d d=%h exp 0/0/1/0/0", Out_valid, Busy, In_ready, Job_count, Out_data); end
        tick();
        Rst_n = 1'b1;
        push(2'd1, EXP1);
        waitOut("t6_dec_b");
        tick();
        Out_ready = 1'b0;
        push(2'd0, 78'd5);
        waitOut("t6_enc");
        push(2'd0, 78'd6);
        #2;
        Rst_n = 1'b0;
        #1;
        checks++; if (Out_valid !== 1'b0 || Busy !== 1'b0 || In_ready !== 1'b1 || Out_data !== '0 || Out_tag_err !== 1'b0) begin
            failures++; $display("FAIL t6_out_rst got v=%0b b=%0b r=%0b d=%h exp 0/0/1/0", Out_valid, Busy, In_ready, Out_data); end
        tick();
        Rst_n = 1'b1;
        Out_ready = 1'b1;
        push(2'd2, '0);
        tick();
        checks++; if (Out_valid !== 1'b1 || Out_data !== '0 || Out_mode !== 2'd2) begin
            failures++; $display("FAIL t6_replay got v=%0b d=%h m=%0d exp 1/0/2", Out_valid, Out_data, Out_mode); end
        repeat (3) tick();
        checks++; if (Busy !== 1'b0 || Out_valid !== 1'b0 || Job_count !== 16'd1) begin
            failures++; $display("FAIL t6_fifo_empty got b=%0b v=%0b c=%0d exp 0/0/1", Busy, Out_valid, Job_count); end
    endtask

    initial begin
        test_reset();
        test_encrypt_latency();
        test_decrypt_replay();
        test_tag_error();
        test_back_to_back();
        test_round_trip();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
